// File: rtl/regfile_sb_if.sv
// ---------------------------------------------------------------------------
// regfile_sb_if
// Bundle of every non-clock signal of the register file / scoreboard.
//
// Handshake semantics: this bus has no valid/ready pair. Every request
// (we, rsv_en, flush) is a single-cycle strobe that the register file always
// accepts and samples on the rising clock edge. Read ports, rdN_pend and
// rsv_conflict are combinational responses to the current request. pend_count
// and err are registered and change only on the edge.
//
// Modports:
//   master : decode / writeback side (drives addresses, data and strobes)
//   slave  : register file (drives read data, pending flags, status)
// ---------------------------------------------------------------------------
interface regfile_sb_if #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
);
    localparam int AW = $clog2(NREGS);
    localparam int CW = $clog2(NREGS + 1);

    // Read side
    logic [AW-1:0]   rs1;
    logic [AW-1:0]   rs2;
    logic [XLEN-1:0] rdout1;
    logic [XLEN-1:0] rdout2;
    logic            rd1_pend;
    logic            rd2_pend;

    // Writeback side
    logic            we;
    logic [AW-1:0]   wraddr;
    logic [XLEN-1:0] wrdata;

    // Scoreboard side
    logic            rsv_en;
    logic [AW-1:0]   rsv_addr;
    logic            flush;
    logic            rsv_conflict;
    logic [CW-1:0]   pend_count;
    logic            err;

    modport master (
        output rs1, rs2, we, wraddr, wrdata, rsv_en, rsv_addr, flush,
        input  rdout1, rdout2, rd1_pend, rd2_pend, rsv_conflict, pend_count, err
    );

    modport slave (
        input  rs1, rs2, we, wraddr, wrdata, rsv_en, rsv_addr, flush,
        output rdout1, rdout2, rd1_pend, rd2_pend, rsv_conflict, pend_count, err
    );
endinterface

// File: rtl/regfile_sb.sv
// ---------------------------------------------------------------------------
// regfile_sb
// Parametrised register file with an integrated pending-bit scoreboard.
// x0 is hardwired to zero and can never be pending. A writeback stores data
// and clears the pending bit; a reservation sets it. When both hit the same
// register in one cycle the data is written and the reservation wins. flush
// clears every pending bit but does not block the data write.
//
// Parameters:
//   XLEN   : data width
//   NREGS  : register count (power of two, >= 2)
//   BYPASS : 1 = same-cycle write forwarded to read data and pending flags
//
// Ports:
//   clk : clock, all state on the rising edge
//   rst : asynchronous active-high reset
//   bus : regfile_sb_if.slave (read ports, writeback, reservation, status)
// ---------------------------------------------------------------------------
module regfile_sb #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int BYPASS = 1
) (
    input  logic         clk,
    input  logic         rst,
    regfile_sb_if.slave  bus
);
    localparam int AW = $clog2(NREGS);
    localparam int CW = $clog2(NREGS + 1);

    logic [XLEN-1:0]  r_mem [NREGS];
    logic [NREGS-1:0] r_pend;
    logic [CW-1:0]    r_pend_count;
    logic             r_err;

    logic w_wr_hit;
    logic w_rsv_hit;
    logic w_same_addr;
    logic w_conflict;
    logic w_orphan;
    logic w_inc;
    logic w_dec;
    logic w_byp1;
    logic w_byp2;

    // A write or reservation to x0 is a no-op everywhere.
    assign w_wr_hit    = bus.we && (bus.wraddr != '0);
    assign w_rsv_hit   = bus.rsv_en && (bus.rsv_addr != '0);
    assign w_same_addr = w_wr_hit && w_rsv_hit && (bus.wraddr == bus.rsv_addr);

    assign w_conflict = w_rsv_hit && r_pend[bus.rsv_addr]
                        && !(bus.we && (bus.wraddr == bus.rsv_addr));
    assign w_orphan   = w_wr_hit && !r_pend[bus.wraddr] && !bus.flush;

    // Count changes track real bit transitions: a set only counts on a
    // currently-clear bit, a clear only on a currently-set bit that is not
    // being re-reserved in the same cycle.
    assign w_inc = w_rsv_hit && !r_pend[bus.rsv_addr];
    assign w_dec = w_wr_hit && r_pend[bus.wraddr] && !w_same_addr;

    // Forwarding select per read port; the rs != 0 term keeps x0 at zero.
    assign w_byp1 = (BYPASS != 0) && bus.we && (bus.wraddr == bus.rs1) && (bus.rs1 != '0);
    assign w_byp2 = (BYPASS != 0) && bus.we && (bus.wraddr == bus.rs2) && (bus.rs2 != '0);

    assign bus.rdout1   = w_byp1 ? bus.wrdata : r_mem[bus.rs1];
    assign bus.rdout2   = w_byp2 ? bus.wrdata : r_mem[bus.rs2];
    assign bus.rd1_pend = w_byp1 ? 1'b0 : r_pend[bus.rs1];
    assign bus.rd2_pend = w_byp2 ? 1'b0 : r_pend[bus.rs2];

    assign bus.rsv_conflict = w_conflict;
    assign bus.pend_count   = r_pend_count;
    assign bus.err          = r_err;

    // Data array; r_mem[0] is never written so it stays zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_hit) begin
            r_mem[bus.wraddr] <= bus.wrdata;
        end
    end

    // Pending bits; the reserve assignment comes last so it wins a
    // same-address collision with a writeback.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend <= '0;
        end else if (bus.flush) begin
            r_pend <= '0;
        end else begin
            if (w_wr_hit) begin
                r_pend[bus.wraddr] <= 1'b0;
            end
            if (w_rsv_hit) begin
                r_pend[bus.rsv_addr] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend_count <= '0;
        end else if (bus.flush) begin
            r_pend_count <= '0;
        end else if (w_inc && !w_dec) begin
            r_pend_count <= r_pend_count + CW'(1);
        end else if (w_dec && !w_inc) begin
            r_pend_count <= r_pend_count - CW'(1);
        end
    end

    // Sticky protocol error: double reservation or orphan writeback.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_conflict || w_orphan) begin
            r_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;

  logic clk;
  logic rst;

  logic [4:0]  b_rs1, b_rs2, b_wraddr, b_rsv_addr;
  logic [31:0] b_wrdata;
  logic        b_we, b_rsv_en, b_flush;

  int n_checks;
  int n_errors;
  bit cmp_en;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- two builds: bypass on and off ----------------
  regfile_sb_if #(.XLEN(XLEN), .NREGS(NREGS)) ifc1 ();
  regfile_sb_if #(.XLEN(XLEN), .NREGS(NREGS)) ifc0 ();

  assign ifc1.rs1 = b_rs1;       assign ifc0.rs1 = b_rs1;
  assign ifc1.rs2 = b_rs2;       assign ifc0.rs2 = b_rs2;
  assign ifc1.we = b_we;         assign ifc0.we = b_we;
  assign ifc1.wraddr = b_wraddr; assign ifc0.wraddr = b_wraddr;
  assign ifc1.wrdata = b_wrdata; assign ifc0.wrdata = b_wrdata;
  assign ifc1.rsv_en = b_rsv_en; assign ifc0.rsv_en = b_rsv_en;
  assign ifc1.rsv_addr = b_rsv_addr; assign ifc0.rsv_addr = b_rsv_addr;
  assign ifc1.flush = b_flush;   assign ifc0.flush = b_flush;

  regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .BYPASS(1)) u_dut_b1 (
    .clk(clk), .rst(rst), .bus(ifc1.slave));
  regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .BYPASS(0)) u_dut_b0 (
    .clk(clk), .rst(rst), .bus(ifc0.slave));

  // ---------------- behavioural model ----------------
  logic [31:0] m_x [32];
  logic [31:0] m_pend;
  logic        m_err;

  function automatic logic [31:0] next_pend();
    logic [31:0] p;
    p = m_pend;
    if (b_we && b_wraddr != 0) p[b_wraddr] = 1'b0;
    if (b_rsv_en && b_rsv_addr != 0) p[b_rsv_addr] = 1'b1;
    if (b_flush) p = '0;
    return p;
  endfunction

  function automatic logic e_conf();
    return b_rsv_en && b_rsv_addr != 0 && m_pend[b_rsv_addr]
           && !(b_we && b_wraddr == b_rsv_addr);
  endfunction

  function automatic logic e_orphan();
    return b_we && b_wraddr != 0 && !m_pend[b_wraddr] && !b_flush;
  endfunction

  function automatic logic [31:0] e_rd(input logic [4:0] rs, input bit byp);
    if (rs == 0) return 32'h0;
    if (byp && b_we && b_wraddr == rs) return b_wrdata;
    return m_x[rs];
  endfunction

  function automatic logic e_pnd(input logic [4:0] rs, input bit byp);
    if (byp && b_we && b_wraddr == rs) return 1'b0;
    return m_pend[rs];
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) m_x[i] <= '0;
      m_pend <= '0;
      m_err  <= 1'b0;
    end else begin
      if (b_we && b_wraddr != 0) m_x[b_wraddr] <= b_wrdata;
      m_pend <= next_pend();
      m_err  <= m_err | e_conf() | e_orphan();
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("b1_rdout1", ifc1.rdout1, e_rd(b_rs1, 1'b1));
    chk("b1_rdout2", ifc1.rdout2, e_rd(b_rs2, 1'b1));
    chk("b1_rd1_pend", ifc1.rd1_pend, e_pnd(b_rs1, 1'b1));
    chk("b1_rd2_pend", ifc1.rd2_pend, e_pnd(b_rs2, 1'b1));
    chk("b1_conflict", ifc1.rsv_conflict, e_conf());
    chk("b1_pend_count", ifc1.pend_count, $countones(m_pend));
    chk("b1_err", ifc1.err, m_err);
    chk("b0_rdout1", ifc0.rdout1, e_rd(b_rs1, 1'b0));
    chk("b0_rdout2", ifc0.rdout2, e_rd(b_rs2, 1'b0));
    chk("b0_rd1_pend", ifc0.rd1_pend, e_pnd(b_rs1, 1'b0));
    chk("b0_rd2_pend", ifc0.rd2_pend, e_pnd(b_rs2, 1'b0));
    chk("b0_conflict", ifc0.rsv_conflict, e_conf());
    chk("b0_pend_count", ifc0.pend_count, $countones(m_pend));
    chk("b0_err", ifc0.err, m_err);
  endtask

  always @(negedge clk) begin
    if (cmp_en) compare_all();
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input logic [4:0] rs1, input logic [4:0] rs2);
    b_we = 0; b_wraddr = 0; b_wrdata = 0;
    b_rsv_en = 0; b_rsv_addr = 0; b_flush = 0;
    b_rs1 = rs1; b_rs2 = rs2;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reserve(input logic [4:0] a);
    idle(0, 0);
    b_rsv_en = 1; b_rsv_addr = a;
    step();
  endtask

  task automatic write(input logic [4:0] a, input logic [31:0] d);
    idle(0, 0);
    b_we = 1; b_wraddr = a; b_wrdata = d;
    step();
  endtask

  // Pulse reset between edges (called right after an edge).
  task automatic pulse_reset();
    idle(0, 0);
    #1 rst = 1;
    #2 rst = 0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    n_checks = 0;
    n_errors = 0;
    cmp_en = 0;
    rst = 1;
    idle(0, 0);
    step();
    step();
    rst = 0;
    step();
    cmp_en = 1;

    // Reset state
    chk("reset_pend_count", ifc1.pend_count, 0);
    chk("reset_err", ifc1.err, 0);

    // Asynchronous reset mid-cycle
    reserve(7);
    reserve(5);
    write(5, 32'hDEADBEEF);
    idle(5, 7);
    #1;
    chk("pre_rst_rdout1", ifc1.rdout1, 32'hDEADBEEF);
    chk("pre_rst_rd2_pend", ifc1.rd2_pend, 1);
    rst = 1;
    #1;
    chk("rst_rdout1", ifc1.rdout1, 0);
    chk("rst_rd2_pend", ifc1.rd2_pend, 0);
    chk("rst_pend_count", ifc1.pend_count, 0);
    chk("rst_err", ifc1.err, 0);
    chk("rst_b0_rdout1", ifc0.rdout1, 0);
    #1 rst = 0;
    step();

    // Bypass vs no bypass
    reserve(3);
    chk("byp_count_before", ifc1.pend_count, 1);
    idle(3, 0);
    b_we = 1; b_wraddr = 3; b_wrdata = 32'h1234;
    #1;
    chk("byp1_rdout1", ifc1.rdout1, 32'h1234);
    chk("byp1_rd1_pend", ifc1.rd1_pend, 0);
    chk("byp0_rdout1", ifc0.rdout1, 0);
    chk("byp0_rd1_pend", ifc0.rd1_pend, 1);
    step();
    chk("byp_count_after", ifc1.pend_count, 0);
    chk("byp_err", ifc1.err, 0);

    // Register 0
    idle(0, 0);
    b_we = 1; b_wraddr = 0; b_wrdata = 32'hFFFFFFFF;
    b_rsv_en = 1; b_rsv_addr = 0;
    #1;
    chk("x0_rdout1", ifc1.rdout1, 0);
    chk("x0_rd1_pend", ifc1.rd1_pend, 0);
    step();
    idle(0, 0);
    #1;
    chk("x0_rdout1_after", ifc0.rdout1, 0);
    chk("x0_pend_count", ifc1.pend_count, 0);
    chk("x0_err", ifc1.err, 0);

    // Reserve/write collision
    reserve(9);
    idle(9, 0);
    b_we = 1; b_wraddr = 9; b_wrdata = 32'hAA;
    b_rsv_en = 1; b_rsv_addr = 9;
    #1;
    chk("coll_conflict", ifc1.rsv_conflict, 0);
    step();
    idle(9, 0);
    #1;
    chk("coll_rdout1", ifc0.rdout1, 32'hAA);
    chk("coll_rd1_pend", ifc1.rd1_pend, 1);
    chk("coll_pend_count", ifc1.pend_count, 1);
    chk("coll_err", ifc1.err, 0);

    // Double reservation
    reserve(4);
    idle(0, 0);
    b_rsv_en = 1; b_rsv_addr = 4;
    #1;
    chk("dbl_conflict", ifc1.rsv_conflict, 1);
    step();
    chk("dbl_err", ifc1.err, 1);
    idle(0, 0);
    step();
    chk("dbl_err_sticky", ifc1.err, 1);

    // Orphan writeback
    pulse_reset();
    step();
    chk("orph_err_clear", ifc1.err, 0);
    write(6, 32'h66);
    chk("orph_err", ifc1.err, 1);
    chk("orph_b0_err", ifc0.err, 1);

    // Flush
    pulse_reset();
    step();
    for (int i = 1; i < 32; i++) reserve(i[4:0]);
    chk("flush_full_count", ifc1.pend_count, 31);
    idle(8, 2);
    b_flush = 1;
    b_rsv_en = 1; b_rsv_addr = 2;
    b_we = 1; b_wraddr = 8; b_wrdata = 32'h55;
    step();
    idle(8, 2);
    #1;
    chk("flush_count", ifc1.pend_count, 0);
    chk("flush_rd1_pend", ifc1.rd1_pend, 0);
    chk("flush_rd2_pend", ifc1.rd2_pend, 0);
    chk("flush_rdout1", ifc1.rdout1, 32'h55);
    chk("flush_b0_count", ifc0.pend_count, 0);

    // Randomised traffic against the model
    pulse_reset();
    step();
    for (int n = 0; n < 3000; n++) begin
      logic [4:0] hi;
      hi = ($urandom_range(0, 1) == 0) ? 5'd7 : 5'd31;
      idle(5'($urandom_range(0, int'(hi))), 5'($urandom_range(0, int'(hi))));
      b_we       = ($urandom_range(0, 1) == 1);
      b_wraddr   = 5'($urandom_range(0, int'(hi)));
      b_wrdata   = $urandom;
      b_rsv_en   = ($urandom_range(0, 9) < 5);
      b_rsv_addr = 5'($urandom_range(0, int'(hi)));
      b_flush    = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 3) == 0) b_rs1 = b_wraddr;
      if ($urandom_range(0, 3) == 0) b_rs2 = b_rsv_addr;
      if ($urandom_range(0, 299) == 0) begin
        #1 rst = 1;
        #2 rst = 0;
      end
      step();
    end

    idle(0, 0);
    step();
    cmp_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
